pwm_multi: RTL and testbench

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_multi.sv | 159 +++++++++++++++
 tb/tb_pwm_multi.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a shared W-bit period counter.
// Supports edge-aligned (sawtooth) and center-aligned (triangle) counting.
// Duty values are double-buffered: new values wait in pending registers and
// move to the active registers only at a period boundary, so a period is
// never cut short or stretched by a mid-period update. The counting mode is
// latched at the same boundary for the same reason.
// A registered blanking flag marks the low part of each period, where current
// sensing is not trustworthy.

module pwm_multi #(
  parameter int W     = 11,
  parameter int NCH   = 3,
  parameter int BLANK = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             center,
  input  logic [NCH*W-1:0] duty,
  input  logic             duty_vld,
  output logic [NCH-1:0]   PWM_sig,
  output logic             PWM_synch,
  output logic             OVR_I_blank_n
);

  // Counter direction. Edge mode only ever uses UP.
  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  // Counting mode currently in force (not the requested one).
  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } mode_e;

  // Top of the counter range, the turnaround point of the up ramp,
  // and the blanking threshold, all at counter width.
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_TOP = {{(W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] BLANK_W = W'(BLANK);

  logic [W-1:0]            cnt_q, cnt_d;
  dir_e                    dir_q, dir_d;
  mode_e                   mode_q, mode_d;
  logic [NCH-1:0][W-1:0]   duty_in;
  logic [NCH-1:0][W-1:0]   pend_q, pend_d;
  logic [NCH-1:0][W-1:0]   act_q, act_d;
  logic [NCH-1:0]          pwm_q, pwm_d;
  logic                    synch_q, synch_d;
  logic                    blank_n_q, blank_n_d;
  logic                    boundary;

  // View the flat duty bus as one W-bit field per channel (channel i at [i*W +: W]).
  assign duty_in = duty;

  // A boundary is the last cycle of an edge period, or the bottom of the up
  // ramp in center mode. Nothing is a boundary while the counter is frozen.
  always_comb begin
    boundary = 1'b0;
    if (en) begin
      if (mode_q == MODE_EDGE) begin
        boundary = (cnt_q == CNT_MAX);
      end else begin
        boundary = (cnt_q == '0) && (dir_q == UP);
      end
    end
  end

  // The mode request is sampled only at a boundary so a period always
  // completes in the mode it started in.
  always_comb begin
    mode_d = mode_q;
    if (boundary) begin
      mode_d = center ? MODE_CENTER : MODE_EDGE;
    end
  end

  // Counter and direction. A boundary that lands in edge mode restarts at 0
  // (this also covers leaving center mode, which restarts the sawtooth).
  // Entering center mode from edge needs no special case: the edge wrap from
  // the top already yields 0 going UP.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (en) begin
      if (boundary && (mode_d == MODE_EDGE)) begin
        cnt_d = '0;
        dir_d = UP;
      end else if (mode_q == MODE_EDGE) begin
        cnt_d = cnt_q + ONE;
        dir_d = UP;
      end else if (dir_q == UP) begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == CNT_TOP) begin
          dir_d = DOWN;
        end
      end else begin
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) begin
          dir_d = UP;
        end
      end
    end
  end

  // Pending duty follows every strobe, even while disabled. Active duty takes
  // the pending value at a boundary; a strobe in the boundary cycle itself
  // bypasses the pending stage so it is not delayed a whole period.
  always_comb begin
    pend_d = duty_vld ? duty_in : pend_q;
    act_d  = act_q;
    if (boundary) begin
      act_d = pend_d;
    end
  end

  // Next values of the registered outputs: per-channel compare, boundary
  // pulse and blanking flag, all forced low while disabled.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NCH; i++) begin
      pwm_d[i] = en && (cnt_q < act_q[i]);
    end
    synch_d   = boundary;
    blank_n_d = en && (cnt_q > BLANK_W);
  end

  // State and output registers; reset drops everything to an idle edge-mode
  // state with zero duty, discarding any pending update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      dir_q     <= UP;
      mode_q    <= MODE_EDGE;
      pend_q    <= '0;
      act_q     <= '0;
      pwm_q     <= '0;
      synch_q   <= 1'b0;
      blank_n_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      pend_q    <= pend_d;
      act_q     <= act_d;
      pwm_q     <= pwm_d;
      synch_q   <= synch_d;
      blank_n_q <= blank_n_d;
    end
  end

  assign PWM_sig       = pwm_q;
  assign PWM_synch     = synch_q;
  assign OVR_I_blank_n = blank_n_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi with W=4, NCH=2, BLANK=3.
// Expected per-period statistics are queued when stimulus is driven and
// compared once the DUT has produced that period.

module tb_pwm_multi;

  localparam int W     = 4;
  localparam int NCH   = 2;
  localparam int BLANK = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             center;
  logic [NCH*W-1:0] duty;
  logic             duty_vld;
  logic [NCH-1:0]   PWM_sig;
  logic             PWM_synch;
  logic             OVR_I_blank_n;

  typedef struct packed {
    logic [7:0] hi0;
    logic [7:0] hi1;
    logic [7:0] bl;
    logic [7:0] sy;
  } period_t;

  period_t exp_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;

  pwm_multi #(.W(W), .NCH(NCH), .BLANK(BLANK)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .center       (center),
    .duty         (duty),
    .duty_vld     (duty_vld),
    .PWM_sig      (PWM_sig),
    .PWM_synch    (PWM_synch),
    .OVR_I_blank_n(OVR_I_blank_n)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Hard stop in case something wedges
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic string fmt(period_t p);
    return $sformatf("hi0=%0d hi1=%0d blank_hi=%0d synch=%0d", p.hi0, p.hi1, p.bl, p.sy);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles, optionally strobing vld_duty in cycle vld_at, and tally outputs.
  task automatic run_period(input int n, input int vld_at, input logic [NCH*W-1:0] vld_duty,
                            output period_t obs, output logic [63:0] mask0);
    obs   = '0;
    mask0 = '0;
    for (int k = 0; k < n; k++) begin
      if (k == vld_at) begin
        duty     = vld_duty;
        duty_vld = 1'b1;
      end else begin
        duty_vld = 1'b0;
      end
      step();
      if (PWM_sig[0])    obs.hi0 = obs.hi0 + 8'd1;
      if (PWM_sig[1])    obs.hi1 = obs.hi1 + 8'd1;
      if (OVR_I_blank_n) obs.bl  = obs.bl + 8'd1;
      if (PWM_synch)     obs.sy  = obs.sy + 8'd1;
      mask0[k] = PWM_sig[0];
    end
    duty_vld = 1'b0;
  endtask

  // Step until PWM_synch is seen or the budget runs out.
  task automatic wait_synch(input int budget, output int steps, output bit ok);
    steps = 0;
    ok    = 1'b0;
    while (steps < budget && !ok) begin
      step();
      steps++;
      if (PWM_synch) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    en       = 1'b0;
    center   = 1'b0;
    duty     = '0;
    duty_vld = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({PWM_sig, PWM_synch, OVR_I_blank_n} !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b, expected 0000", {PWM_sig, PWM_synch, OVR_I_blank_n});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_edge();
    period_t obs, exp;
    logic [63:0] m;
    int steps;
    bit ok;
    en       = 1'b1;
    duty     = {4'd0, 4'd5};
    duty_vld = 1'b1;
    exp_q.push_back(period_t'{hi0: 8'd5, hi1: 8'd0, bl: 8'd12, sy: 8'd1});
    exp_q.push_back(period_t'{hi0: 8'd5, hi1: 8'd0, bl: 8'd12, sy: 8'd1});
    step();
    duty_vld = 1'b0;
    wait_synch(40, steps, ok);
    n_checks++;
    if (!ok || steps !== 15) begin
      n_fail++;
      $display("[TB] FAIL edge_first_boundary: synch after %0d more cycles (seen=%0d), expected 15", steps, ok);
    end
    for (int p = 0; p < 2; p++) begin
      run_period(16, -1, duty, obs, m);
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL edge_period%0d: got %s, expected %s", p, fmt(obs), fmt(exp));
      end
    end
  endtask

  task automatic test_shadow();
    period_t obs, exp;
    logic [63:0] m;
    exp_q.push_back(period_t'{hi0: 8'd5, hi1: 8'd0, bl: 8'd12, sy: 8'd1});
    exp_q.push_back(period_t'{hi0: 8'd12, hi1: 8'd9, bl: 8'd12, sy: 8'd1});
    run_period(16, 7, {4'd9, 4'd12}, obs, m);
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL shadow_current: got %s, expected %s", fmt(obs), fmt(exp));
    end
    run_period(16, -1, duty, obs, m);
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL shadow_next: got %s, expected %s", fmt(obs), fmt(exp));
    end
  endtask

  task automatic test_simultaneous();
    period_t obs, exp;
    logic [63:0] m;
    exp_q.push_back(period_t'{hi0: 8'd12, hi1: 8'd9, bl: 8'd12, sy: 8'd1});
    exp_q.push_back(period_t'{hi0: 8'd15, hi1: 8'd9, bl: 8'd12, sy: 8'd1});
    run_period(16, 15, {4'd9, 4'd15}, obs, m);
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL simul_current: got %s, expected %s", fmt(obs), fmt(exp));
    end
    run_period(16, -1, duty, obs, m);
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL simul_next: got %s, expected %s", fmt(obs), fmt(exp));
    end
    n_checks++;
    if (m[15:0] !== 16'h7FFF) begin
      n_fail++;
      $display("[TB] FAIL simul_low_only_at_top: got pattern %h, expected 7fff", m[15:0]);
    end
  endtask

  task automatic test_center();
    period_t obs, exp;
    logic [63:0] m, exp_mask;
    int steps, mm, c, run;
    bit ok;
    center = 1'b1;
    exp_q.push_back(period_t'{hi0: 8'd15, hi1: 8'd9, bl: 8'd12, sy: 8'd1});
    exp_q.push_back(period_t'{hi0: 8'd7, hi1: 8'd17, bl: 8'd23, sy: 8'd1});
    run_period(16, 3, {4'd9, 4'd4}, obs, m);
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL center_request_period: got %s, expected %s", fmt(obs), fmt(exp));
    end
    wait_synch(40, steps, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL center_entry: no synch within %0d cycles, expected one", steps);
    end
    run_period(30, -1, duty, obs, m);
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL center_period: got %s, expected %s", fmt(obs), fmt(exp));
    end
    exp_mask = '0;
    for (int k = 0; k < 30; k++) begin
      mm = k + 1;
      c  = (mm <= 15) ? mm : 30 - mm;
      exp_mask[k] = (c < 4);
    end
    n_checks++;
    if (m !== exp_mask) begin
      n_fail++;
      $display("[TB] FAIL center_symmetry: got pattern %h, expected %h", m, exp_mask);
    end
    run = 0;
    repeat (3) begin
      step();
      if (PWM_sig[0]) run++;
    end
    n_checks++;
    if (run !== 3) begin
      n_fail++;
      $display("[TB] FAIL center_run_continues: got %0d high cycles, expected 3", run);
    end
  endtask

  task automatic test_enable();
    period_t obs, exp;
    logic [63:0] m;
    int steps, bad;
    bit ok;
    center = 1'b0;
    wait_synch(64, steps, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL edge_return_boundary: no synch within %0d cycles, expected one", steps);
    end
    exp_q.push_back(period_t'{hi0: 8'd4, hi1: 8'd9, bl: 8'd12, sy: 8'd1});
    run_period(16, -1, duty, obs, m);
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL edge_return_period: got %s, expected %s", fmt(obs), fmt(exp));
    end
    repeat (9) step();
    en       = 1'b0;
    duty     = {4'd2, 4'd6};
    duty_vld = 1'b1;
    exp_q.push_back(period_t'{hi0: 8'd6, hi1: 8'd2, bl: 8'd12, sy: 8'd1});
    step();
    duty_vld = 1'b0;
    n_checks++;
    if ({PWM_sig, PWM_synch, OVR_I_blank_n} !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL disable_outputs: got %b, expected 0000", {PWM_sig, PWM_synch, OVR_I_blank_n});
    end
    bad = 0;
    repeat (4) begin
      step();
      if ({PWM_sig, PWM_synch, OVR_I_blank_n} !== 4'd0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("[TB] FAIL disable_hold: got %0d active cycles, expected 0", bad);
    end
    en = 1'b1;
    wait_synch(40, steps, ok);
    n_checks++;
    if (!ok || steps !== 7) begin
      n_fail++;
      $display("[TB] FAIL resume_position: synch after %0d cycles (seen=%0d), expected 7", steps, ok);
    end
    run_period(16, -1, duty, obs, m);
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL pending_while_disabled: got %s, expected %s", fmt(obs), fmt(exp));
    end
  endtask

  task automatic test_reset_mid();
    period_t obs, exp;
    logic [63:0] m;
    int steps;
    bit ok;
    repeat (5) step();
    center   = 1'b1;
    duty     = {4'd13, 4'd13};
    duty_vld = 1'b1;
    step();
    duty_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({PWM_sig, PWM_synch, OVR_I_blank_n} !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_async: got %b, expected 0000", {PWM_sig, PWM_synch, OVR_I_blank_n});
    end
    center = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    exp_q.push_back(period_t'{hi0: 8'd0, hi1: 8'd0, bl: 8'd12, sy: 8'd1});
    wait_synch(40, steps, ok);
    n_checks++;
    if (!ok || steps !== 16) begin
      n_fail++;
      $display("[TB] FAIL reset_first_period: synch after %0d cycles (seen=%0d), expected 16", steps, ok);
    end
    run_period(16, -1, duty, obs, m);
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL reset_clears_pending: got %s, expected %s", fmt(obs), fmt(exp));
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_shadow();
    test_simultaneous();
    test_center();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
